alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Single-cycle logic and arithmetic ops complete with 1 registered cycle of latency.
- Unsigned multiply and divide/remainder run iteratively, one bit per cycle.
- Sits between register-read and writeback; valid/ready handshakes on input and output let the pipeline stall on long ops.

Parameters:
- DATA_WIDTH, 32, operand/result width; power of two, >= 8.
- OPCODE_LENGTH, 4, Operation field width; fixed at 4 for the encoding below.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/Operation valid.
- in_ready  output  1  unit can accept a new operation.
- SrcA  input  DATA_WIDTH  operand A.
- SrcB  input  DATA_WIDTH  operand B.
- Operation  input  OPCODE_LENGTH  op select.
- out_valid  output  1  ALUResult valid.
- out_ready  input  1  consumer accepts result.
- ALUResult  output  DATA_WIDTH  registered result.
- Zero  output  1  ALUResult == 0, registered with ALUResult.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset (async assert, sync deassert by the reset tree): state=IDLE; in_ready=1, out_valid=0, ALUResult=0, Zero=0 (it is not recomputed from ALUResult during reset), busy=0; counter and internal operand/accumulator registers cleared. Reset mid-operation aborts the op with no result produced.
- Encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB (A-B).
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is SrcB[$clog2(DATA_WIDTH)-1:0].
  - 1000 EQ (1 if A==B else 0), 1001 SLT signed, 1010 SLTU.
  - 1011 MUL (low DATA_WIDTH bits of A*B), 1100 MULHU (high DATA_WIDTH bits of unsigned A*B).
  - 1101 DIVU, 1110 REMU; 1111 reserved -> result 0, single-cycle.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH, no carry/overflow output. Compare results are zero-extended to DATA_WIDTH.
- FSM states IDLE, BUSY, DONE.
  - in_ready = (state==IDLE). Accept = in_valid && in_ready at a rising edge.
  - IDLE, accept, single-cycle op -> DONE; ALUResult/Zero loaded on the accepting edge.
  - IDLE, accept, op 1011-1110 -> BUSY; operands latched, counter=DATA_WIDTH, busy=1.
  - BUSY: one iteration per cycle (shift-add multiply / restoring divide), counter decrements. At counter==1, that edge loads the final result and moves to DONE. Inputs are ignored during BUSY.
  - DONE: out_valid=1, ALUResult/Zero held stable until out_ready. On out_valid && out_ready -> IDLE.
- Latency, edges from accepting edge to out_valid high: single-cycle ops 1; iterative ops DATA_WIDTH+1.
- Throughput: one op in flight; the next accept is possible on the edge after the output handshake.
- Divide by zero (DIVU/REMU with SrcB==0): still takes DATA_WIDTH+1 cycles; DIVU returns all ones, REMU returns SrcA.
- DATA_WIDTH=1-bit corner: not supported (minimum 8).
- out_ready held high: IDLE->DONE->IDLE; in_ready is low for exactly one cycle per single-cycle op.
- SrcA/SrcB/Operation may change after the accepting edge without affecting the in-flight result.

Test Plan:
- Reset during BUSY of MUL: deassert reset_n mid-iteration -> out_valid=0, in_ready=1 immediately; the next op (ADD 2+3) returns 5 with no stale output.
- Single-cycle sweep, out_ready=1: ADD 0xFFFFFFFF+1 -> 0, Zero=1; SUB 3-5 -> 0xFFFFFFFE; SRA 0x80000000 by 4 -> 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0; EQ 7,7 -> 1; each out_valid exactly 1 edge after accept.
- MUL 0x12345678*0x10 -> 0x23456780 and MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; out_valid at edge 33 after accept, busy high for 32 cycles, in_ready low throughout.
- DIVU 100/7 -> 14 and REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; each takes 33 cycles.
- Backpressure: out_ready=0 for 10 cycles after a DIVU completes -> ALUResult and out_valid stable, in_ready=0 and new in_valid ignored; raising out_ready completes the handshake and in_ready=1 the next cycle.
- Operand change while BUSY: SrcA/SrcB toggled randomly during a MUL -> result matches the latched operands; reserved opcode 1111 -> 0, Zero=1.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned multiply and divide.
// Valid/ready handshakes on both sides; one operation in flight at a time.
module alu_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero,
  output logic                     busy
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready high
  // BUSY  | iterating multiply/divide, one bit per cycle
  // DONE  | result held on ALUResult until out_ready

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam int SHW       = $clog2(DATA_WIDTH);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND   = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] OP_OR    = 4'b0001;
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = 4'b0011;
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = 4'b0100;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = 4'b0101;
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL   = 4'b0110;
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA   = 4'b0111;
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ    = 4'b1000;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = 4'b1001;
  localparam logic [OPCODE_LENGTH-1:0] OP_SLTU  = 4'b1010;
  localparam logic [OPCODE_LENGTH-1:0] OP_MUL   = 4'b1011;
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHU = 4'b1100;
  localparam logic [OPCODE_LENGTH-1:0] OP_DIVU  = 4'b1101;
  localparam logic [OPCODE_LENGTH-1:0] OP_REMU  = 4'b1110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                   state_q;
  logic                     in_ready_q, out_valid_q, busy_q, zero_q;
  logic [DATA_WIDTH-1:0]    result_q;
  logic [CNT_WIDTH-1:0]     cnt_q;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic [DATA_WIDTH-1:0]    hi_q, lo_q, b_q;

  logic [DATA_WIDTH-1:0]    alu_res_d;
  logic                     is_iter;
  logic [SHW-1:0]           shamt;
  logic [DATA_WIDTH:0]      mul_sum, rem_sh;
  logic [DATA_WIDTH-1:0]    rem_sub, hi_d, lo_d, iter_res_d;
  logic                     rem_ge, op_is_mul;

  assign shamt   = SrcB[SHW-1:0];
  assign is_iter = (Operation == OP_MUL) || (Operation == OP_MULHU) ||
                   (Operation == OP_DIVU) || (Operation == OP_REMU);

  always_comb begin
    alu_res_d = '0;
    case (Operation)
      OP_AND:  alu_res_d = SrcA & SrcB;
      OP_OR:   alu_res_d = SrcA | SrcB;
      OP_ADD:  alu_res_d = SrcA + SrcB;
      OP_XOR:  alu_res_d = SrcA ^ SrcB;
      OP_SUB:  alu_res_d = SrcA - SrcB;
      OP_SLL:  alu_res_d = SrcA << shamt;
      OP_SRL:  alu_res_d = SrcA >> shamt;
      OP_SRA:  alu_res_d = $unsigned($signed(SrcA) >>> shamt);
      OP_EQ:   alu_res_d = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
      OP_SLT:  alu_res_d = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      OP_SLTU: alu_res_d = {{(DATA_WIDTH-1){1'b0}}, SrcA < SrcB};
      default: alu_res_d = '0;
    endcase
  end

  // hi/lo hold {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
  // A zero divisor always "fits", which naturally yields all-ones quotient and remainder = A.
  always_comb begin
    op_is_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh    = {hi_q, lo_q[DATA_WIDTH-1]};
    rem_ge    = rem_sh >= {1'b0, b_q};
    rem_sub   = rem_sh[DATA_WIDTH-1:0] - b_q;
    if (op_is_mul) begin
      hi_d = mul_sum[DATA_WIDTH:1];
      lo_d = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
    end else begin
      hi_d = rem_ge ? rem_sub : rem_sh[DATA_WIDTH-1:0];
      lo_d = {lo_q[DATA_WIDTH-2:0], rem_ge};
    end
    iter_res_d = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? lo_d : hi_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (is_iter) begin
              state_q <= BUSY;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_WIDTH'(DATA_WIDTH);
              op_q    <= Operation;
              hi_q    <= '0;
              lo_q    <= SrcA;
              b_q     <= SrcB;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res_d;
              zero_q      <= (alu_res_d == '0);
            end
          end
        end
        BUSY: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            result_q    <= iter_res_d;
            zero_q      <= (iter_res_d == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table with a result scoreboard plus
// hand-written reset-abort and backpressure sequences.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready, out_valid, out_ready, Zero, busy;
  logic [W-1:0] SrcA, SrcB, ALUResult;
  logic [3:0]   Operation;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    string        name;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           lat;
    string        name;
  } vec_t;
  vec_t vecs[$];

  alu_seq #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Results are compared when the output handshake is about to happen.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h with no pending operation", ALUResult);
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_result"}, 64'(ALUResult), 64'(e.res));
        chk({e.name, "_zero"}, 64'(Zero), 64'(e.zero));
      end
    end
  end

  task automatic wait_ready(input string name);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (in_ready !== 1'b1) chk({name, "_in_ready_timeout"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input vec_t v);
    int lat, busy_n, rdy_n;
    wait_ready(v.name);
    in_valid  = 1'b1;
    Operation = v.op;
    SrcA      = v.a;
    SrcB      = v.b;
    sb_q.push_back('{v.res, (v.res == '0), v.name});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; busy_n = 0; rdy_n = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_n++;
      if (in_ready !== 1'b0) rdy_n++;
      SrcA      = $urandom;
      SrcB      = $urandom;
      Operation = 4'($urandom_range(0, 15));
      in_valid  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (in_ready !== 1'b0) rdy_n++;
    chk({v.name, "_latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, "_busy_cycles"}, 64'(busy_n), 64'(v.lat - 1));
    chk({v.name, "_in_ready_high_cycles"}, 64'(rdy_n), 64'd0);
    @(posedge clk); #1;
    chk({v.name, "_in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    SrcA = '0; SrcB = '0; Operation = '0;

    vecs.push_back('{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1,  "add_wrap"});
    vecs.push_back('{4'b0100, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1,  "sub_neg"});
    vecs.push_back('{4'b0111, 32'h80000000, 32'h00000004, 32'hF8000000, 1,  "sra"});
    vecs.push_back('{4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1,  "slt"});
    vecs.push_back('{4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1,  "sltu"});
    vecs.push_back('{4'b1000, 32'h00000007, 32'h00000007, 32'h00000001, 1,  "eq_true"});
    vecs.push_back('{4'b1000, 32'h00000007, 32'h00000008, 32'h00000000, 1,  "eq_false"});
    vecs.push_back('{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1,  "and"});
    vecs.push_back('{4'b0001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1,  "or"});
    vecs.push_back('{4'b0011, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1,  "xor"});
    vecs.push_back('{4'b0101, 32'h00000001, 32'h00000025, 32'h00000020, 1,  "sll_masked"});
    vecs.push_back('{4'b0110, 32'h80000000, 32'h0000001F, 32'h00000001, 1,  "srl"});
    vecs.push_back('{4'b1111, 32'h00000012, 32'h00000034, 32'h00000000, 1,  "reserved"});
    vecs.push_back('{4'b1011, 32'h12345678, 32'h00000010, 32'h23456780, 33, "mul"});
    vecs.push_back('{4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu"});
    vecs.push_back('{4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, "mul_low_max"});
    vecs.push_back('{4'b1101, 32'h00000064, 32'h00000007, 32'h0000000E, 33, "divu"});
    vecs.push_back('{4'b1110, 32'h00000064, 32'h00000007, 32'h00000002, 33, "remu"});
    vecs.push_back('{4'b1101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 33, "divu_by0"});
    vecs.push_back('{4'b1110, 32'h00000005, 32'h00000000, 32'h00000005, 33, "remu_by0"});
    vecs.push_back('{4'b1101, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 33, "divu_big"});
    vecs.push_back('{4'b1110, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 33, "remu_big"});

    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(ALUResult), 64'd0);
    chk("reset_zero", 64'(Zero), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a multiply: op aborted, no result appears.
    in_valid = 1'b1; Operation = 4'b1011; SrcA = 32'h0000_1234; SrcB = 32'h0000_0011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op('{4'b0010, 32'd2, 32'd3, 32'd5, 1, "post_reset_add"});

    foreach (vecs[i]) run_op(vecs[i]);

    // Backpressure on a completed divide.
    out_ready = 1'b0;
    wait_ready("bp");
    in_valid = 1'b1; Operation = 4'b1101; SrcA = 32'd1000; SrcB = 32'd10;
    sb_q.push_back('{32'd100, 1'b0, "bp_divu"});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'd33);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; Operation = 4'b0010; SrcA = $urandom; SrcB = $urandom;
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_result", 64'(ALUResult), 64'd100);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
